// File: rtl/rgb565_video_framer.sv
// Frames an RGB565 pixel stream into AXI4-Stream RGB888 beats with tuser on the first
// pixel of a frame and tlast on the last pixel of each line; starts and stops on whole frames.
module rgb565_video_framer #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        o_frame_done,
    output logic        o_busy
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // eof marks the beat whose transfer completes the frame
    typedef struct packed {
        logic [23:0] data;
        logic        user;
        logic        last;
        logic        eof;
    } beat_t;

    state_t          state, state_nxt;
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    beat_t           beat_q, beat_nxt;
    logic            tvalid_q;
    logic            done_q;

    logic x_last, y_last, ready, accept, xfer, frame_end;

    function automatic logic [23:0] expand(input logic [15:0] d);
        return {d[15:11], 3'b000, d[10:5], 2'b00, d[4:0], 3'b000};
    endfunction

    assign x_last    = (x_cnt == X_MAX);
    assign y_last    = (y_cnt == Y_MAX);
    assign ready     = (state == ACTIVE) && (!tvalid_q || m_axis_tready);
    assign accept    = i_valid && ready;
    assign xfer      = tvalid_q && m_axis_tready;
    assign frame_end = accept && x_last && y_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_enable) state_nxt = ACTIVE;
            ACTIVE:  if (frame_end && !i_enable) state_nxt = DRAIN;
            DRAIN:   if (xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || state == IDLE) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (accept) begin
            if (x_last) begin
                x_cnt <= '0;
                y_cnt <= y_last ? '0 : y_cnt + YW'(1);
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

    always_comb begin
        beat_nxt.data = expand(i_data);
        beat_nxt.user = (x_cnt == '0) && (y_cnt == '0);
        beat_nxt.last = x_last;
        beat_nxt.eof  = x_last && y_last;
    end

    // A beat leaving and a pixel arriving in the same cycle keeps tvalid high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            beat_q   <= '0;
            tvalid_q <= 1'b0;
        end else if (accept) begin
            beat_q   <= beat_nxt;
            tvalid_q <= 1'b1;
        end else if (xfer) begin
            tvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) done_q <= 1'b0;
        else       done_q <= xfer && beat_q.eof;
    end

    assign o_ready       = ready;
    assign m_axis_tdata  = beat_q.data;
    assign m_axis_tuser  = beat_q.user;
    assign m_axis_tlast  = beat_q.last;
    assign m_axis_tvalid = tvalid_q;
    assign o_frame_done  = done_q;
    assign o_busy        = (state != IDLE);

endmodule
